// File: rtl/welford_divide_if.sv
// rtl/welford_divide_if.sv - request/result handshake bundle for the welford divider
// Carries the remainder only when WELFORD_DIVIDE_REMAINDER_EN is defined.
interface welford_divide_if #(
  parameter int DIVIDEND_WIDTH = 37,
  parameter int DIVISOR_WIDTH  = 18
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic                      div_by_zero;
  logic                      overflow;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
  logic [DIVISOR_WIDTH-1:0]  remainder;
`endif

  modport master (
`ifdef WELFORD_DIVIDE_REMAINDER_EN
    input  remainder,
`endif
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero, overflow
  );

  modport slave (
`ifdef WELFORD_DIVIDE_REMAINDER_EN
    output remainder,
`endif
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero, overflow
  );
endinterface

// File: rtl/welford_divide.sv
// rtl/welford_divide.sv - restoring signed divider, one quotient bit per clock
// Optional signed remainder output: define WELFORD_DIVIDE_REMAINDER_EN.
module welford_divide #(
  parameter int DIVIDEND_WIDTH = 37,
  parameter int DIVISOR_WIDTH  = 18,
  parameter int CNT_WIDTH      = 6
) (
  input  logic            axis_aclk,
  input  logic            axis_resetn,
  welford_divide_if.slave bus
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_e;
  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [DW-1:0]        dvd_q;
  logic [VW-1:0]        dvs_q;
  logic [VW-1:0]        rem_q;
  logic                 neg_q;
  logic                 dneg_q;
  logic                 dz_q;
  logic                 ov_q;
  logic                 fix_q;
  logic [DW-1:0]        quotient_q;
  logic                 dz_out_q;
  logic                 ov_out_q;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
  logic [VW-1:0]        remainder_q;
`endif

  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   rem_sh;
  logic          ge;
  logic [VW-1:0] rem_nx;

  // dvd_q doubles as the quotient register: dividend bits shift out the top, quotient bits in at the bottom
  always_comb begin
    dvd_mag = bus.dividend[DW-1] ? DW'(0) - bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[VW-1] ? VW'(0) - bus.divisor : bus.divisor;
    rem_sh  = {rem_q, dvd_q[DW-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_nx  = ge ? rem_sh[VW-1:0] - dvs_q : rem_sh[VW-1:0];
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = ITER;
      ITER:    if (cnt_q == '0)   state_d = SIGN;
      SIGN:    if (fix_q)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      dneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      fix_q      <= 1'b0;
      quotient_q <= '0;
      dz_out_q   <= 1'b0;
      ov_out_q   <= 1'b0;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
      remainder_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          dvd_q  <= dvd_mag;
          dvs_q  <= dvs_mag;
          rem_q  <= '0;
          neg_q  <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
          dneg_q <= bus.dividend[DW-1];
          dz_q   <= (bus.divisor == '0);
          ov_q   <= (bus.dividend == Q_MIN) && (&bus.divisor);
          cnt_q  <= CNT_WIDTH'(DW - 1);
          fix_q  <= 1'b0;
        end
        ITER: begin
          dvd_q <= {dvd_q[DW-2:0], ge};
          rem_q <= rem_nx;
          cnt_q <= cnt_q - 1'b1;
        end
        // first SIGN cycle applies the signs, second selects the special cases into the outputs
        SIGN: if (!fix_q) begin
          fix_q <= 1'b1;
          dvd_q <= neg_q ? DW'(0) - dvd_q : dvd_q;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
          rem_q <= dneg_q ? VW'(0) - rem_q : rem_q;
`endif
        end else begin
          if (dz_q)      quotient_q <= dneg_q ? Q_MIN : Q_MAX;
          else if (ov_q) quotient_q <= Q_MAX;
          else           quotient_q <= dvd_q;
          dz_out_q <= dz_q;
          ov_out_q <= ov_q;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
          remainder_q <= (dz_q || ov_q) ? '0 : rem_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.overflow    = ov_out_q;
`ifdef WELFORD_DIVIDE_REMAINDER_EN
  assign bus.remainder   = remainder_q;
`endif
endmodule
